// File: rtl/gyro_pkg.sv
// Shared definitions for the SPI gyro register slave: register addresses,
// frame layout and the frame FSM state type.
package gyro_pkg;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL5     = 7'h14;
  localparam logic [6:0] ADDR_YAW_L     = 7'h26;
  localparam logic [6:0] ADDR_YAW_H     = 7'h27;

  localparam int         RW_BIT      = 15;
  localparam logic [4:0] FRAME_BITS  = 5'd16;
  localparam logic [4:0] CMD_BITS    = 5'd8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } gyro_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous serial input; RST_VAL is the
// idle level the line is assumed to sit at while in reset.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_gyro_serf.sv
// SPI (mode 3) register slave modelling a yaw gyro: 16-bit R/W frames,
// a small register map, yaw sample capture and a data-ready interrupt.
module spi_gyro_serf
  import gyro_pkg::*;
#(
  parameter logic [7:0] INT_EN_VAL = 8'h02,
  parameter logic [7:0] WHO_AM_I   = 8'h6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] yaw_smpl,
  input  logic        smpl_vld,
  output gyro_state_e o_dbg_state
);

  logic        w_ss_s, w_sclk_s, w_mosi_s;
  logic        r_ss_d, r_sclk_d;
  logic [1:0]  r_ss_hi_cnt;
  gyro_state_e r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [15:0] r_rx;
  logic [7:0]  r_tx;
  logic [7:0]  r_int1_ctrl, r_ctrl2_g, r_ctrl5, r_yaw_l, r_yaw_h;
  logic        r_int;
  logic        r_smpl_since_snap;

  spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.i_clk(clk), .i_rst_n(rst_n), .i_d(SS_n), .o_q(w_ss_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_sclk (.i_clk(clk), .i_rst_n(rst_n), .i_d(SCLK), .o_q(w_sclk_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.i_clk(clk), .i_rst_n(rst_n), .i_d(MOSI), .o_q(w_mosi_s));

  // A fall only starts a frame once SS_n has been seen high for a few clocks,
  // so a line still held low across reset release cannot open a half frame.
  logic w_ss_fall, w_ss_rise, w_rise, w_fall;
  assign w_ss_fall = r_ss_d & ~w_ss_s & (r_ss_hi_cnt == 2'd3);
  assign w_ss_rise = ~r_ss_d & w_ss_s;
  assign w_rise    = (r_state == ST_SHIFT) & w_sclk_s & ~r_sclk_d;
  assign w_fall    = (r_state == ST_SHIFT) & ~w_sclk_s & r_sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
      r_ss_hi_cnt <= 2'd0;
    end else begin
      r_ss_d   <= w_ss_s;
      r_sclk_d <= w_sclk_s;
      if (!w_ss_s)                  r_ss_hi_cnt <= 2'd0;
      else if (r_ss_hi_cnt != 2'd3) r_ss_hi_cnt <= r_ss_hi_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_ss_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  logic [15:0] w_rx_nxt;
  logic        w_cmd_done;
  logic [7:0]  w_rd_val;
  assign w_rx_nxt   = {r_rx[14:0], w_mosi_s};
  assign w_cmd_done = w_rise & (r_cnt == CMD_BITS - 5'd1);

  always_comb begin
    w_rd_val = 8'h00;
    case (w_rx_nxt[6:0])
      ADDR_INT1_CTRL: w_rd_val = r_int1_ctrl;
      ADDR_WHO_AM_I:  w_rd_val = WHO_AM_I;
      ADDR_CTRL2_G:   w_rd_val = r_ctrl2_g;
      ADDR_CTRL5:     w_rd_val = r_ctrl5;
      ADDR_YAW_L:     w_rd_val = r_yaw_l;
      ADDR_YAW_H:     w_rd_val = r_yaw_h;
      default:        w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
      r_rx  <= 16'h0000;
      r_tx  <= 8'h00;
    end else begin
      if (w_ss_fall)                        r_cnt <= 5'd0;
      else if (w_rise && r_cnt != FRAME_BITS) r_cnt <= r_cnt + 5'd1;
      if (w_rise) r_rx <= w_rx_nxt;
      if (w_cmd_done)                     r_tx <= w_rx_nxt[7] ? w_rd_val : 8'h00;
      else if (w_fall && r_cnt >= CMD_BITS) r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  logic       w_frame_ok, w_wr;
  logic [6:0] w_addr;
  logic [7:0] w_wdata;
  assign w_frame_ok = w_ss_rise & (r_state == ST_SHIFT) & (r_cnt == FRAME_BITS);
  assign w_wr       = w_frame_ok & ~r_rx[RW_BIT];
  assign w_addr     = r_rx[14:8];
  assign w_wdata    = r_rx[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int1_ctrl <= 8'h00;
      r_ctrl2_g   <= 8'h00;
      r_ctrl5     <= 8'h00;
      r_yaw_l     <= 8'h00;
      r_yaw_h     <= 8'h00;
    end else begin
      if (w_wr) begin
        case (w_addr)
          ADDR_INT1_CTRL: r_int1_ctrl <= w_wdata;
          ADDR_CTRL2_G:   r_ctrl2_g   <= w_wdata;
          ADDR_CTRL5:     r_ctrl5     <= w_wdata;
          default: ;
        endcase
      end
      if (smpl_vld) begin
        r_yaw_l <= yaw_smpl[7:0];
        r_yaw_h <= yaw_smpl[15:8];
      end
    end
  end

  // A sample landing after the yawH snapshot was not delivered by that read,
  // so the end of the read must not clear its interrupt.
  logic w_int_set, w_int_clr;
  assign w_int_set = smpl_vld & (r_int1_ctrl == INT_EN_VAL);
  assign w_int_clr = (w_frame_ok & r_rx[RW_BIT] & (w_addr == ADDR_YAW_H) & ~r_smpl_since_snap)
                   | (w_wr & (w_addr == ADDR_INT1_CTRL) & (w_wdata != INT_EN_VAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int             <= 1'b0;
      r_smpl_since_snap <= 1'b0;
    end else begin
      if (w_int_set)      r_int <= 1'b1;
      else if (w_int_clr) r_int <= 1'b0;
      if (w_int_set)       r_smpl_since_snap <= 1'b1;
      else if (w_cmd_done) r_smpl_since_snap <= 1'b0;
    end
  end

  assign MISO        = (r_state == ST_SHIFT && r_cnt >= CMD_BITS) ? r_tx[7] : 1'b0;
  assign INT         = r_int;
  assign o_dbg_state = r_state;

endmodule
